// File: rtl/gpu_apb_master_pkg.sv
// Shared types for the GPU APB command master: bus FSM states and the
// 32-bit GPU command word layout.
package gpu_apb_pkg;

  localparam int OPCODE_W = 4;
  localparam int PARAM_W  = 28;
  localparam int CMD_W    = OPCODE_W + PARAM_W;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_t;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [PARAM_W-1:0]  parameters;
  } gpu_cmd_t;

endpackage

// File: rtl/gpu_apb_master_if.sv
// Host command handshake, APB write bus and status/control signals of the
// GPU APB command master, bundled with master/slave views.
interface gpu_apb_master_if;
  import gpu_apb_pkg::*;

  // host command side
  logic                cmd_valid_i;
  logic                cmd_ready_o;
  logic [OPCODE_W-1:0] opcode_i;
  logic [PARAM_W-1:0]  parameters_i;

  // APB side
  logic [31:0]         pAddr_o;
  logic [CMD_W-1:0]    pDataWrite_o;
  logic                pSel_o;
  logic                pEnable_o;
  logic                pWrite_o;
  logic                pReady_i;
  logic                pSlvErr_i;

  // status / control
  logic                busy_o;
  logic                error_o;
  logic                clear_err_i;

  // the block itself
  modport master (
    input  cmd_valid_i, opcode_i, parameters_i, pReady_i, pSlvErr_i, clear_err_i,
    output cmd_ready_o, pAddr_o, pDataWrite_o, pSel_o, pEnable_o, pWrite_o,
           busy_o, error_o
  );

  // the environment around it (host source + APB slave)
  modport slave (
    output cmd_valid_i, opcode_i, parameters_i, pReady_i, pSlvErr_i, clear_err_i,
    input  cmd_ready_o, pAddr_o, pDataWrite_o, pSel_o, pEnable_o, pWrite_o,
           busy_o, error_o
  );

endinterface

// File: rtl/gpu_apb_master_cmd_fifo.sv
// Circular command buffer with extra-MSB pointers: equal pointers mean
// empty, pointers differing only in the MSB mean full. Head is read
// combinationally so the bus FSM can register it on the pop edge.
module gpu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; wraps naturally through the extra MSB.
  // NOTE: sequential state always uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop  && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write.
  // NOTE: the array has no reset; its contents are only observed through rd_ptr after a write, so resetting it would only cost flops.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/gpu_apb_master.sv
// GPU APB command master: buffers host commands and issues each one as an
// APB write (SETUP then ACCESS) to CMD_ADDR. All bus outputs are registered.
// Optional: define GPU_APB_MASTER_TIMEOUT_EN to abandon an ACCESS phase that
// waits TIMEOUT_CYCLES cycles without pReady_i (flags error_o).
module gpu_apb_master
  import gpu_apb_pkg::*;
#(
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [31:0] CMD_ADDR       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  gpu_apb_master_if.master  bus
);

  // Reject configurations the pointer scheme and timeout counter cannot handle.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("gpu_apb_master: FIFO_DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 1");
  end

  apb_state_t state;
  gpu_cmd_t   push_cmd;
  gpu_cmd_t   head_cmd;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic       access_abort;
  logic       access_done;

  assign push_cmd        = '{opcode: bus.opcode_i, parameters: bus.parameters_i};
  assign bus.cmd_ready_o = !fifo_full;
  assign fifo_push       = bus.cmd_valid_i && !fifo_full;
  assign bus.busy_o      = (state != IDLE) || !fifo_empty;

`ifdef GPU_APB_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;

  assign access_abort = (state == ACCESS) && !bus.pReady_i &&
                        (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Count ACCESS cycles spent waiting; restarts on every SETUP.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tmo_cnt <= '0;
    end else if (state == SETUP) begin
      tmo_cnt <= '0;
    end else if (state == ACCESS && !bus.pReady_i) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  assign access_abort = 1'b0;
`endif

  // ACCESS ends on slave ready or on an abandoned wait; either frees the bus.
  assign access_done = (state == ACCESS) && (bus.pReady_i || access_abort);
  assign fifo_pop    = !fifo_empty && ((state == IDLE) || access_done);

  gpu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (push_cmd),
    .rd_data (head_cmd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // APB sequencer and registered bus outputs; sticky error with set-over-clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state            <= IDLE;
      bus.pSel_o       <= 1'b0;
      bus.pEnable_o    <= 1'b0;
      bus.pWrite_o     <= 1'b0;
      bus.pAddr_o      <= '0;
      bus.pDataWrite_o <= '0;
      bus.error_o      <= 1'b0;
    end else begin
      if (access_done && ((bus.pReady_i && bus.pSlvErr_i) || access_abort)) begin
        bus.error_o <= 1'b1;
      end else if (bus.clear_err_i) begin
        bus.error_o <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state            <= SETUP;
            bus.pSel_o       <= 1'b1;
            bus.pEnable_o    <= 1'b0;
            bus.pWrite_o     <= 1'b1;
            bus.pAddr_o      <= CMD_ADDR;
            bus.pDataWrite_o <= head_cmd;
          end
        end
        SETUP: begin
          state         <= ACCESS;
          bus.pEnable_o <= 1'b1;
        end
        ACCESS: begin
          if (access_done) begin
            if (!fifo_empty) begin
              state            <= SETUP;
              bus.pEnable_o    <= 1'b0;
              bus.pDataWrite_o <= head_cmd;
            end else begin
              state         <= IDLE;
              bus.pSel_o    <= 1'b0;
              bus.pEnable_o <= 1'b0;
              bus.pWrite_o  <= 1'b0;
            end
          end
        end
        default: begin
          state         <= IDLE;
          bus.pSel_o    <= 1'b0;
          bus.pEnable_o <= 1'b0;
          bus.pWrite_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_apb_master.sv
// Self-checking bench for gpu_apb_master: directed latency/handshake/error
// scenarios plus randomized traffic, scored against a queue-based model of
// accepted commands, completed APB writes and the sticky error flag.
module tb_gpu_apb_master;
  import gpu_apb_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] ADDR  = 32'h4000_0100;
  localparam int          TMO   = 16;

  logic clk   = 1'b0;
  logic n_rst = 1'b1;

  always #5 clk = ~clk;

  gpu_apb_master_if bus ();

  gpu_apb_master #(
    .FIFO_DEPTH     (DEPTH),
    .CMD_ADDR       (ADDR),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q holds every accepted command not yet completed on the bus
  // (buffered ones plus the one currently on the bus, if any).
  logic [31:0] exp_q[$];
  logic        exp_err    = 1'b0;
  int          acc_cycles = 0;
  int          n_acc      = 0;
  int          n_done     = 0;
  int          n_abort    = 0;

  always @(negedge clk) begin
    if (!n_rst) begin
      exp_q.delete();
      exp_err    = 1'b0;
      acc_cycles = 0;
    end else begin
      check("busy", 32'(bus.busy_o), 32'(exp_q.size() != 0));
      check("cmd_ready", 32'(bus.cmd_ready_o),
            32'((exp_q.size() - (bus.pSel_o ? 1 : 0)) < DEPTH));
      check("error", 32'(bus.error_o), 32'(exp_err));
      check("pwrite_vs_psel", 32'(bus.pWrite_o), 32'(bus.pSel_o));
      check("enable_without_sel", 32'(bus.pEnable_o && !bus.pSel_o), 32'(0));

      if (bus.clear_err_i) exp_err = 1'b0;
      if (bus.pSel_o && bus.pEnable_o) begin
        acc_cycles++;
        if (bus.pReady_i) begin
          if (exp_q.size() == 0) begin
            check("spurious_write", 32'(1), 32'(0));
          end else begin
            check("pdata", bus.pDataWrite_o, exp_q.pop_front());
            check("paddr", bus.pAddr_o, ADDR);
          end
          n_done++;
          acc_cycles = 0;
          if (bus.pSlvErr_i) exp_err = 1'b1;
        end
`ifdef GPU_APB_MASTER_TIMEOUT_EN
        else if (acc_cycles == TMO) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          exp_err    = 1'b1;
          acc_cycles = 0;
          n_abort++;
        end
`endif
      end
      if (bus.cmd_valid_i && bus.cmd_ready_o) begin
        exp_q.push_back({bus.opcode_i, bus.parameters_i});
        n_acc++;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] cmd);
    bus.cmd_valid_i = 1'b1;
    {bus.opcode_i, bus.parameters_i} = cmd;
    tick();
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_access(input string tag);
    int n = 0;
    while (!(bus.pSel_o && bus.pEnable_o) && n < 50) begin
      tick();
      n++;
    end
    if (!(bus.pSel_o && bus.pEnable_o)) check({tag, "_no_access"}, 32'(0), 32'(1));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy_o && n < 300) begin
      tick();
      n++;
    end
    if (bus.busy_o) check({tag, "_stuck_busy"}, 32'(bus.busy_o), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] b2b [3];
    logic [31:0] held_addr;
    logic [31:0] held_data;
    int acc0, done0, abort0;
    int sel_first, sel_last, sel_n, en_bad;

    bus.cmd_valid_i  = 1'b0;
    bus.opcode_i     = '0;
    bus.parameters_i = '0;
    bus.pReady_i     = 1'b1;
    bus.pSlvErr_i    = 1'b0;
    bus.clear_err_i  = 1'b0;

    // reset state
    #2 n_rst = 1'b0;
    #1;
    check("rst_psel",    32'(bus.pSel_o),    32'(0));
    check("rst_penable", 32'(bus.pEnable_o), 32'(0));
    check("rst_pwrite",  32'(bus.pWrite_o),  32'(0));
    check("rst_busy",    32'(bus.busy_o),    32'(0));
    check("rst_error",   32'(bus.error_o),   32'(0));
    check("rst_paddr",   bus.pAddr_o,        32'h0);
    check("rst_pdata",   bus.pDataWrite_o,   32'h0);
    repeat (2) @(negedge clk);
    #1 n_rst = 1'b1;
    tick();
    check("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'(1));

    // single command latency: pSel at edge 2, pEnable at edge 3, idle at edge 4
    bus.cmd_valid_i  = 1'b1;
    bus.opcode_i     = 4'h3;
    bus.parameters_i = 28'h00000AB;
    tick();
    bus.cmd_valid_i = 1'b0;
    tick();
    check("single_e2_psel",    32'(bus.pSel_o),    32'(1));
    check("single_e2_penable", 32'(bus.pEnable_o), 32'(0));
    check("single_e2_pdata",   bus.pDataWrite_o,   32'h3000_00AB);
    check("single_e2_paddr",   bus.pAddr_o,        ADDR);
    tick();
    check("single_e3_penable", 32'(bus.pEnable_o), 32'(1));
    tick();
    check("single_e4_psel", 32'(bus.pSel_o), 32'(0));
    check("single_e4_busy", 32'(bus.busy_o), 32'(0));
    check("single_e4_pdata_held", bus.pDataWrite_o, 32'h3000_00AB);

    // back-to-back: three pushes, six contiguous pSel cycles, pEnable 0/1
    b2b[0] = 32'h1000_0001;
    b2b[1] = 32'h2000_0002;
    b2b[2] = 32'h3000_0003;
    done0 = n_done;
    sel_first = -1; sel_last = -1; sel_n = 0; en_bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 3) begin
        bus.cmd_valid_i = 1'b1;
        {bus.opcode_i, bus.parameters_i} = b2b[i];
      end else begin
        bus.cmd_valid_i = 1'b0;
      end
      tick();
      if (bus.pSel_o) begin
        if (sel_first < 0) sel_first = i;
        sel_last = i;
        sel_n++;
        if (bus.pEnable_o != ((i - sel_first) % 2 == 1)) en_bad++;
      end
    end
    check("b2b_first_sel",  32'(sel_first), 32'(1));
    check("b2b_sel_cycles", 32'(sel_n), 32'(6));
    check("b2b_contiguous", 32'(sel_last - sel_first + 1), 32'(6));
    check("b2b_enable_pattern", 32'(en_bad), 32'(0));
    check("b2b_done", 32'(n_done - done0), 32'(3));

    // full FIFO: slave stalls, six offers -> 4 buffered + 1 in flight
    wait_idle("full_pre");
    bus.pReady_i = 1'b0;
    acc0  = n_acc;
    done0 = n_done;
    for (int i = 0; i < 6; i++) begin
      bus.cmd_valid_i = 1'b1;
      {bus.opcode_i, bus.parameters_i} = 32'hA000_0000 + 32'(i);
      tick();
    end
    bus.cmd_valid_i = 1'b0;
    check("full_cmd_ready", 32'(bus.cmd_ready_o), 32'(0));
    check("full_accepted", 32'(n_acc - acc0), 32'(5));
    bus.pReady_i = 1'b1;
    wait_idle("full_drain");
    check("full_done", 32'(n_done - done0), 32'(5));

    // wait states: three stalled ACCESS cycles then ready
    bus.pReady_i = 1'b0;
    done0 = n_done;
    push_one(32'h5123_4567);
    wait_access("wait");
    held_addr = bus.pAddr_o;
    held_data = bus.pDataWrite_o;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_penable", 32'(bus.pEnable_o), 32'(1));
      check("wait_paddr", bus.pAddr_o, held_addr);
      check("wait_pdata", bus.pDataWrite_o, held_data);
      if (i == 2) bus.pReady_i = 1'b1;
    end
    tick();
    check("wait_release_psel", 32'(bus.pSel_o), 32'(0));
    check("wait_done", 32'(n_done - done0), 32'(1));
    check("wait_pdata_value", held_data, 32'h5123_4567);

    // slave error: set, set-over-clear, lone clear
    bus.pSlvErr_i = 1'b1;
    push_one(32'h6000_0006);
    wait_access("err1");
    tick();
    check("err_set", 32'(bus.error_o), 32'(1));
    push_one(32'h7000_0007);
    wait_access("err2");
    bus.clear_err_i = 1'b1;
    tick();
    bus.clear_err_i = 1'b0;
    check("err_set_wins", 32'(bus.error_o), 32'(1));
    bus.pSlvErr_i   = 1'b0;
    bus.clear_err_i = 1'b1;
    tick();
    bus.clear_err_i = 1'b0;
    check("err_clear", 32'(bus.error_o), 32'(0));

    // asynchronous reset while in ACCESS
    bus.pReady_i = 1'b0;
    push_one(32'h8000_0008);
    push_one(32'h9000_0009);
    wait_access("arst");
    #2 n_rst = 1'b0;
    #1;
    check("arst_psel",    32'(bus.pSel_o),    32'(0));
    check("arst_penable", 32'(bus.pEnable_o), 32'(0));
    check("arst_busy",    32'(bus.busy_o),    32'(0));
    @(negedge clk);
    #1 n_rst = 1'b1;
    bus.pReady_i = 1'b1;
    tick();
    check("arst_cmd_ready", 32'(bus.cmd_ready_o), 32'(1));
    check("arst_idle_psel", 32'(bus.pSel_o),      32'(0));

`ifdef GPU_APB_MASTER_TIMEOUT_EN
    // timeout: slave never responds, abort after TMO ACCESS cycles
    begin
      int n;
      bus.pReady_i = 1'b0;
      abort0 = n_abort;
      push_one(32'hB000_000B);
      wait_access("tmo");
      n = 1;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (!(bus.pSel_o && bus.pEnable_o)) break;
        n++;
      end
      check("tmo_access_cycles", 32'(n), 32'(TMO));
      check("tmo_error", 32'(bus.error_o), 32'(1));
      check("tmo_aborts", 32'(n_abort - abort0), 32'(1));
      bus.pReady_i    = 1'b1;
      bus.clear_err_i = 1'b1;
      tick();
      bus.clear_err_i = 1'b0;
    end
`endif

    // randomized traffic
    wait_idle("rand_pre");
    acc0   = n_acc;
    done0  = n_done;
    abort0 = n_abort;
    for (int i = 0; i < 1500; i++) begin
      bus.cmd_valid_i  = ($urandom_range(0, 1) == 1);
      bus.opcode_i     = 4'($urandom);
      bus.parameters_i = 28'($urandom);
      bus.pReady_i     = ($urandom_range(0, 9) < 7);
      bus.pSlvErr_i    = ($urandom_range(0, 9) == 0);
      bus.clear_err_i  = ($urandom_range(0, 19) == 0);
      tick();
    end
    bus.cmd_valid_i = 1'b0;
    bus.pReady_i    = 1'b1;
    bus.pSlvErr_i   = 1'b0;
    bus.clear_err_i = 1'b0;
    wait_idle("rand_drain");
    check("rand_model_empty", 32'(exp_q.size()), 32'(0));
    check("rand_accounting", 32'((n_done - done0) + (n_abort - abort0)), 32'(n_acc - acc0));
    check("rand_some_traffic", 32'((n_acc - acc0) > 100), 32'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
